ofdm_symbol_sequencer: RTL and testbench

- Frames a continuous, unmarked baseband sample stream into OFDM symbol packets for the downstream prefix-removal stage.
- A frame-start pulse from the synchroniser arms the block. From then on, every CP_LEN+FFT_LEN accepted beats form one symbol packet, delimited by SOP/EOP and tagged with a symbol index, for a run-time-configured number of symbols.
- Between frames, the input stream is accepted and discarded.

---
 rtl/ofdm_symbol_sequencer.sv | 159 +++++++++++++++
 tb/tb_ofdm_symbol_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_symbol_sequencer.sv
// Frames a continuous sample stream into SOP/EOP-delimited OFDM symbol packets after a frame-start pulse.
// Latency: 1 cycle (single output register stage).
// Backpressure: input ready follows output-register-free while framing; the stream is sunk between frames.
`timescale 1ns/1ps
module ofdm_symbol_sequencer #(
    parameter int DATA_W  = 32,
    parameter int CP_LEN  = 8,
    parameter int FFT_LEN = 64,
    parameter int SYM_W   = 8
) (
    input  logic              clock_clk,
    input  logic              reset_reset_n,
    input  logic              frame_start,
    input  logic [SYM_W-1:0]  cfg_num_symbols,
    input  logic              err_clear,
    input  logic [DATA_W-1:0] asi_in0_data,
    input  logic              asi_in0_valid,
    output logic              asi_in0_ready,
    output logic [DATA_W-1:0] aso_out0_data,
    output logic              aso_out0_valid,
    input  logic              aso_out0_ready,
    output logic              aso_out0_startofpacket,
    output logic              aso_out0_endofpacket,
    output logic [SYM_W-1:0]  aso_out0_symbol,
    output logic              busy,
    output logic              frame_done,
    output logic              err_overrun
);

    localparam int SYM_LEN = CP_LEN + FFT_LEN;
    localparam int CNT_W   = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(SYM_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   sample_cnt, sample_cnt_nxt, cur_sample;
    logic [SYM_W-1:0]   sym_cnt, sym_cnt_nxt, cur_sym;
    logic [SYM_W-1:0]   num_sym, num_sym_nxt, cur_num;
    logic               out_free, start_ok, load;
    logic               load_sop, load_eop, last_beat;
    logic               err_set, frame_done_nxt;

    assign out_free = !aso_out0_valid || aso_out0_ready;
    assign start_ok = frame_start && (cfg_num_symbols != '0);
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt      = state;
        sample_cnt_nxt = sample_cnt;
        sym_cnt_nxt    = sym_cnt;
        num_sym_nxt    = num_sym;
        asi_in0_ready  = 1'b0;
        load           = 1'b0;
        err_set        = 1'b0;
        frame_done_nxt = 1'b0;
        cur_sample     = sample_cnt;
        cur_sym        = sym_cnt;
        cur_num        = num_sym;

        case (state)
            IDLE: begin
                // Hold off only when a start would need the still-occupied output register.
                asi_in0_ready = !start_ok || out_free;
                err_set       = frame_start && !start_ok;
                if (start_ok) begin
                    num_sym_nxt    = cfg_num_symbols;
                    sample_cnt_nxt = '0;
                    sym_cnt_nxt    = '0;
                    cur_sample     = '0;
                    cur_sym        = '0;
                    cur_num        = cfg_num_symbols;
                    load           = asi_in0_valid && out_free;
                    state_nxt      = ARMED;
                end
            end
            ARMED, RUN: begin
                asi_in0_ready = out_free;
                load          = asi_in0_valid && out_free;
                err_set       = frame_start;
            end
            default: state_nxt = IDLE;
        endcase

        load_sop  = (cur_sample == '0);
        load_eop  = (cur_sample == LAST_SAMPLE);
        last_beat = load_eop && (cur_sym == cur_num - SYM_W'(1));

        if (load) begin
            if (last_beat) begin
                state_nxt      = IDLE;
                frame_done_nxt = 1'b1;
                sample_cnt_nxt = '0;
                sym_cnt_nxt    = '0;
            end else begin
                state_nxt = RUN;
                if (load_eop) begin
                    sample_cnt_nxt = '0;
                    sym_cnt_nxt    = cur_sym + SYM_W'(1);
                end else begin
                    sample_cnt_nxt = cur_sample + CNT_W'(1);
                    sym_cnt_nxt    = cur_sym;
                end
            end
        end
    end

    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state      <= IDLE;
            sample_cnt <= '0;
            sym_cnt    <= '0;
            num_sym    <= '0;
        end else begin
            state      <= state_nxt;
            sample_cnt <= sample_cnt_nxt;
            sym_cnt    <= sym_cnt_nxt;
            num_sym    <= num_sym_nxt;
        end
    end

    // Payload fields only move on load, so they hold while the output is stalled.
    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            aso_out0_valid         <= 1'b0;
            aso_out0_data          <= '0;
            aso_out0_startofpacket <= 1'b0;
            aso_out0_endofpacket   <= 1'b0;
            aso_out0_symbol        <= '0;
        end else if (load) begin
            aso_out0_valid         <= 1'b1;
            aso_out0_data          <= asi_in0_data;
            aso_out0_startofpacket <= load_sop;
            aso_out0_endofpacket   <= load_eop;
            aso_out0_symbol        <= cur_sym;
        end else if (aso_out0_ready) begin
            aso_out0_valid         <= 1'b0;
        end
    end

    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            frame_done  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            frame_done <= frame_done_nxt;
            if (err_set) begin
                err_overrun <= 1'b1;
            end else if (err_clear) begin
                err_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ofdm_symbol_sequencer.sv
// Directed bench for ofdm_symbol_sequencer: framing, stalls, error flag and mid-frame reset.
// Latency: checks one-cycle input-to-output delay.
// Backpressure: exercises random downstream ready and verifies held outputs.
`timescale 1ns/1ps
module tb_ofdm_symbol_sequencer;

    localparam int DATA_W  = 32;
    localparam int SYM_W   = 8;
    localparam int SYM_LEN = 72;

    logic              clock_clk = 1'b0;
    logic              reset_reset_n = 1'b0;
    logic              frame_start = 1'b0;
    logic [SYM_W-1:0]  cfg_num_symbols = '0;
    logic              err_clear = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              asi_in0_valid = 1'b0;
    logic              asi_in0_ready;
    logic [DATA_W-1:0] aso_out0_data;
    logic              aso_out0_valid;
    logic              aso_out0_ready = 1'b1;
    logic              aso_out0_startofpacket;
    logic              aso_out0_endofpacket;
    logic [SYM_W-1:0]  aso_out0_symbol;
    logic              busy;
    logic              frame_done;
    logic              err_overrun;

    ofdm_symbol_sequencer #(
        .DATA_W (DATA_W),
        .CP_LEN (8),
        .FFT_LEN(64),
        .SYM_W  (SYM_W)
    ) dut (
        .clock_clk             (clock_clk),
        .reset_reset_n         (reset_reset_n),
        .frame_start           (frame_start),
        .cfg_num_symbols       (cfg_num_symbols),
        .err_clear             (err_clear),
        .asi_in0_data          (in_data),
        .asi_in0_valid         (asi_in0_valid),
        .asi_in0_ready         (asi_in0_ready),
        .aso_out0_data         (aso_out0_data),
        .aso_out0_valid        (aso_out0_valid),
        .aso_out0_ready        (aso_out0_ready),
        .aso_out0_startofpacket(aso_out0_startofpacket),
        .aso_out0_endofpacket  (aso_out0_endofpacket),
        .aso_out0_symbol       (aso_out0_symbol),
        .busy                  (busy),
        .frame_done            (frame_done),
        .err_overrun           (err_overrun)
    );

    always #5 clock_clk = ~clock_clk;

    int          checks = 0;
    int          errors = 0;
    int          out_cnt, sop_cnt, eop_cnt, done_cnt, cyc, first_acc, first_vld;
    logic        in_acc = 1'b0;
    logic        stall_q = 1'b0;
    logic        rand_rdy = 1'b0;
    logic [63:0] held, done_word;

    function automatic logic [63:0] pk(logic v, logic [31:0] d, logic s, logic e, logic [7:0] y);
        return {15'd0, v, d, 6'd0, s, e, y};
    endfunction

    function automatic logic [63:0] exp_beat(int k);
        return pk(1'b1, 32'(k), (k % SYM_LEN) == 0, (k % SYM_LEN) == SYM_LEN - 1, 8'(k / SYM_LEN));
    endfunction

    function automatic logic [63:0] cur_out();
        return pk(aso_out0_valid, aso_out0_data, aso_out0_startofpacket,
                  aso_out0_endofpacket, aso_out0_symbol);
    endfunction

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic new_test();
        out_cnt   = 0;
        sop_cnt   = 0;
        eop_cnt   = 0;
        done_cnt  = 0;
        first_acc = -1;
        first_vld = -1;
        in_data   = '0;
    endtask

    // One clock: observe at the falling edge, then update stimulus just after the rising edge.
    task automatic step();
        logic [63:0] cur;
        @(negedge clock_clk);
        cur = cur_out();
        if (stall_q) check("stall_hold", cur, held);
        if (aso_out0_valid && aso_out0_ready) begin
            check("beat", cur, exp_beat(out_cnt));
            out_cnt++;
            if (aso_out0_startofpacket) sop_cnt++;
            if (aso_out0_endofpacket) eop_cnt++;
        end
        if (aso_out0_valid && first_vld < 0) first_vld = cyc;
        if (frame_done) begin
            done_cnt++;
            done_word = cur;
        end
        stall_q = aso_out0_valid && !aso_out0_ready;
        held    = cur;
        in_acc  = asi_in0_valid && asi_in0_ready;
        if (in_acc && first_acc < 0) first_acc = cyc;
        cyc++;
        @(posedge clock_clk);
        #1;
        if (in_acc) in_data = in_data + 32'd1;
        frame_start = 1'b0;
        err_clear   = 1'b0;
        if (rand_rdy) aso_out0_ready = 1'($urandom_range(0, 1));
    endtask

    initial begin
        cyc = 0;
        new_test();
        repeat (3) @(posedge clock_clk);
        #1;
        check("rst_out", cur_out(), 64'd0);
        check("rst_flags", 64'({busy, frame_done, err_overrun}), 64'd0);
        check("rst_ready", 64'(asi_in0_ready), 64'd1);
        reset_reset_n = 1'b1;
        step();

        // Two symbols, start coincides with the first valid beat.
        new_test();
        cfg_num_symbols = 8'd2;
        asi_in0_valid   = 1'b1;
        frame_start     = 1'b1;
        repeat (160) step();
        check("t1_count", 64'(out_cnt), 64'd144);
        check("t1_sop", 64'(sop_cnt), 64'd2);
        check("t1_eop", 64'(eop_cnt), 64'd2);
        check("t1_done_cnt", 64'(done_cnt), 64'd1);
        check("t1_done_beat", done_word, exp_beat(143));
        check("t1_busy_end", 64'(busy), 64'd0);

        // Armed with an idle input, then the stream arrives.
        new_test();
        asi_in0_valid   = 1'b0;
        cfg_num_symbols = 8'd1;
        frame_start     = 1'b1;
        step();
        repeat (5) step();
        check("t2_armed_busy", 64'(busy), 64'd1);
        check("t2_armed_novld", 64'(aso_out0_valid), 64'd0);
        check("t2_armed_rdy", 64'(asi_in0_ready), 64'd1);
        asi_in0_valid = 1'b1;
        repeat (80) step();
        check("t2_latency", 64'(first_vld - first_acc), 64'd1);
        check("t2_count", 64'(out_cnt), 64'd72);
        check("t2_done_cnt", 64'(done_cnt), 64'd1);

        // Three symbols under random downstream backpressure.
        new_test();
        cfg_num_symbols = 8'd3;
        frame_start     = 1'b1;
        rand_rdy        = 1'b1;
        for (int i = 0; i < 4000 && out_cnt < 216; i++) step();
        rand_rdy       = 1'b0;
        aso_out0_ready = 1'b1;
        repeat (20) step();
        check("t3_count", 64'(out_cnt), 64'd216);
        check("t3_sop", 64'(sop_cnt), 64'd3);
        check("t3_eop", 64'(eop_cnt), 64'd3);
        check("t3_done_cnt", 64'(done_cnt), 64'd1);

        // Stray frame starts mid-frame and on the final EOP beat.
        new_test();
        check("t4_err_pre", 64'(err_overrun), 64'd0);
        cfg_num_symbols = 8'd1;
        for (int i = 0; i < 90; i++) begin
            frame_start = (i == 0) || (in_data == 32'd10) || (in_data == 32'd71);
            step();
        end
        check("t4_count", 64'(out_cnt), 64'd72);
        check("t4_sop", 64'(sop_cnt), 64'd1);
        check("t4_eop", 64'(eop_cnt), 64'd1);
        check("t4_done_cnt", 64'(done_cnt), 64'd1);
        check("t4_busy_end", 64'(busy), 64'd0);
        check("t4_err_set", 64'(err_overrun), 64'd1);
        err_clear = 1'b1;
        step();
        check("t4_err_clr", 64'(err_overrun), 64'd0);

        // Zero-symbol configuration is rejected.
        new_test();
        cfg_num_symbols = 8'd0;
        frame_start     = 1'b1;
        repeat (11) step();
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_err", 64'(err_overrun), 64'd1);
        check("t5_count", 64'(out_cnt), 64'd0);

        // Reset lands while beat 30 sits in the output register.
        new_test();
        cfg_num_symbols = 8'd2;
        frame_start     = 1'b1;
        repeat (31) step();
        check("t6_pre_rst", cur_out(), exp_beat(30));
        reset_reset_n = 1'b0;
        #1;
        check("t6_rst_out", cur_out(), 64'd0);
        check("t6_rst_flags", 64'({busy, frame_done, err_overrun}), 64'd0);
        repeat (2) step();
        reset_reset_n = 1'b1;
        step();
        new_test();
        cfg_num_symbols = 8'd1;
        frame_start     = 1'b1;
        repeat (90) step();
        check("t6_count", 64'(out_cnt), 64'd72);
        check("t6_sop", 64'(sop_cnt), 64'd1);
        check("t6_eop", 64'(eop_cnt), 64'd1);
        check("t6_done_cnt", 64'(done_cnt), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
